paritysel_pingpong_feeder: RTL

- Upstream stage of the parity-select mux.
- Accepts a single valid/ready input stream and writes words alternately into two register banks: A for even words, B for odd words.
- Drives the mux's sel, data_a and data_b, so that the downstream mux output (data_a when sel is even, data_b when sel is odd) always presents the oldest unread word.
- Provides an output valid/ready handshake to the consumer of the mux output.

---
 rtl/paritysel_pkg.sv | 13 +
 rtl/paritysel_bank.sv | 32 +++
 rtl/paritysel_pingpong_feeder.sv | 84 ++++++++
 3 files changed

// File: rtl/paritysel_pkg.sv
// Shared constants and types for the parity-select mux and its feeder.
// Bank parity mapping and counter widths live here.
package paritysel_pkg;

    localparam int SEL_W = 4;
    localparam int OCC_W = 2;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    typedef logic [SEL_W-1:0] cnt_t;

endpackage

// File: rtl/paritysel_bank.sv
// One ping-pong bank: data register plus full flag.
// clr empties the bank but keeps the stored word.
module paritysel_bank
    import paritysel_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            full <= 1'b0;
        end else if (clr) begin
            full <= 1'b0;
        end else if (wr_en) begin
            q    <= d;
            full <= 1'b1;
        end else if (rd_en) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/paritysel_pingpong_feeder.sv
// Feeds the parity-select mux: even words to bank A, odd to bank B.
// sel tracks the oldest unread word; wr_cnt tracks the next slot.
module paritysel_pingpong_feeder
    import paritysel_pkg::*;
#(
    parameter  int WIDTH   = 8,
    localparam int T_WIDTH = WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [T_WIDTH:0] in_data,
    output logic [SEL_W-1:0] sel,
    output logic [T_WIDTH:0] data_a,
    output logic [T_WIDTH:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy
);

    cnt_t       wr_cnt;
    logic       full_a;
    logic       full_b;
    logic [1:0] full;
    logic       wr_fire;
    logic       rd_fire;
    logic       wr_a;
    logic       wr_b;
    logic       rd_a;
    logic       rd_b;

    assign full = {full_b, full_a};

    // Both handshake flags come from registers only.
    assign in_ready  = !full[wr_cnt[0]];
    assign out_valid = full[sel[0]];
    assign occupancy = OCC_W'(full_a) + OCC_W'(full_b);

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;

    assign wr_a = wr_fire && (wr_cnt[0] == BANK_A);
    assign wr_b = wr_fire && (wr_cnt[0] == BANK_B);
    assign rd_a = rd_fire && (sel[0] == BANK_A);
    assign rd_b = rd_fire && (sel[0] == BANK_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            sel    <= '0;
        end else if (flush) begin
            wr_cnt <= '0;
            sel    <= '0;
        end else begin
            if (wr_fire) wr_cnt <= wr_cnt + 1'b1;
            if (rd_fire) sel    <= sel + 1'b1;
        end
    end

    paritysel_bank #(.WIDTH(WIDTH)) u_bank_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .wr_en (wr_a),
        .rd_en (rd_a),
        .d     (in_data),
        .q     (data_a),
        .full  (full_a)
    );

    paritysel_bank #(.WIDTH(WIDTH)) u_bank_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .wr_en (wr_b),
        .rd_en (rd_b),
        .d     (in_data),
        .q     (data_b),
        .full  (full_b)
    );

endmodule
